// File: rtl/forward_hazard_unit.sv
// EX operand-forward selects and ID stall control; optional feature macro: FORWARDING_EN.
// Without FORWARDING_EN the selects stay 00 and ID waits until its producers have reached WB.
module forward_hazard_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  input  logic        id_reg_write,
  input  logic        id_mem_read,
  input  logic        flush,
  output logic [1:0]  forward_a,
  output logic [1:0]  forward_b,
  output logic        stall,
  output logic [15:0] stall_count
);

  typedef struct packed {
    logic       valid;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       reg_write;
    logic       mem_read;
  } stage_t;

  typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;

  localparam stage_t BUBBLE = '0;

  stage_t      id_rec, ex_d, ex_q, mem_q, wb_q;
  state_t      state_d, state_q;
  logic [15:0] stall_count_d, stall_count_q;
  logic        hazard;
  logic        unused_bits;

  // x0 is hard-wired, so a write to it never counts as a producer.
  function automatic logic writes_reg(input stage_t s, input logic [4:0] r);
    return s.valid & s.reg_write & (s.rd != 5'd0) & (s.rd == r);
  endfunction

`ifdef FORWARDING_EN
  function automatic logic [1:0] fwd_sel(input stage_t m, input stage_t w, input logic [4:0] r);
    if (writes_reg(m, r))      return 2'b10;
    else if (writes_reg(w, r)) return 2'b01;
    else                       return 2'b00;
  endfunction

  // Only a load in EX cannot be covered by forwarding; the bubble it inserts clears it next cycle.
  assign hazard = (state_q == RUN) & id_valid & ex_q.valid & ex_q.mem_read & (ex_q.rd != 5'd0)
                & ((ex_q.rd == id_rs1) | (ex_q.rd == id_rs2));
  assign forward_a = fwd_sel(mem_q, wb_q, ex_q.rs1);
  assign forward_b = fwd_sel(mem_q, wb_q, ex_q.rs2);
  assign unused_bits = ^{ex_q.reg_write, mem_q.rs1, mem_q.rs2, mem_q.mem_read,
                         wb_q.rs1, wb_q.rs2, wb_q.mem_read};
`else
  assign hazard = id_valid & (writes_reg(ex_q, id_rs1)  | writes_reg(ex_q, id_rs2)
                            | writes_reg(mem_q, id_rs1) | writes_reg(mem_q, id_rs2));
  assign forward_a = 2'b00;
  assign forward_b = 2'b00;
  assign unused_bits = ^{ex_q.rs1, ex_q.rs2, ex_q.mem_read, mem_q.rs1, mem_q.rs2,
                         mem_q.mem_read, wb_q, state_q};
`endif

  assign stall  = hazard & ~flush;
  assign id_rec = '{valid: id_valid, rs1: id_rs1, rs2: id_rs2, rd: id_rd,
                    reg_write: id_reg_write, mem_read: id_mem_read};
  assign ex_d   = (stall | flush) ? BUBBLE : id_rec;
  assign state_d = stall ? STALL : RUN;
  assign stall_count_d = (stall && (stall_count_q != 16'hFFFF)) ? stall_count_q + 16'd1
                                                                : stall_count_q;
  assign stall_count = stall_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q          <= BUBBLE;
      mem_q         <= BUBBLE;
      wb_q          <= BUBBLE;
      state_q       <= RUN;
      stall_count_q <= 16'd0;
    end else begin
      ex_q          <= ex_d;
      mem_q         <= ex_q;
      wb_q          <= mem_q;
      state_q       <= state_d;
      stall_count_q <= stall_count_d;
    end
  end

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Directed pipeline sequences; expected selects/stall/count queued per cycle, compared on the falling edge.
module tb_forward_hazard_unit;

  typedef struct packed {
    logic       v;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
  } ins_t;

  typedef struct {
    string       tag;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic        st;
    logic [15:0] cnt;
  } exp_t;

  localparam ins_t NOP   = '0;
  localparam ins_t ADD5  = '{1'b1, 5'd1, 5'd2, 5'd5,  1'b1, 1'b0};
  localparam ins_t USE5A = '{1'b1, 5'd5, 5'd3, 5'd6,  1'b1, 1'b0};
  localparam ins_t IND8  = '{1'b1, 5'd1, 5'd2, 5'd8,  1'b1, 1'b0};
  localparam ins_t USE5B = '{1'b1, 5'd3, 5'd5, 5'd9,  1'b1, 1'b0};
  localparam ins_t LW7   = '{1'b1, 5'd1, 5'd0, 5'd7,  1'b1, 1'b1};
  localparam ins_t USE7  = '{1'b1, 5'd7, 5'd2, 5'd10, 1'b1, 1'b0};
  localparam ins_t ADD0  = '{1'b1, 5'd1, 5'd2, 5'd0,  1'b1, 1'b0};
  localparam ins_t LW0   = '{1'b1, 5'd1, 5'd0, 5'd0,  1'b1, 1'b1};
  localparam ins_t USE0  = '{1'b1, 5'd0, 5'd0, 5'd11, 1'b1, 1'b0};
  localparam ins_t LW9   = '{1'b1, 5'd7, 5'd0, 5'd9,  1'b1, 1'b1};
  localparam ins_t USE9  = '{1'b1, 5'd9, 5'd2, 5'd12, 1'b1, 1'b0};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_valid, id_reg_write, id_mem_read, flush;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [1:0]  forward_a, forward_b;
  logic        stall;
  logic [15:0] stall_count;

  int   n_chk = 0;
  int   n_err = 0;
  exp_t sb[$];
  logic [15:0] cbase;

  forward_hazard_unit dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
    .forward_a(forward_a), .forward_b(forward_b), .stall(stall), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, got, want);
    end
  endtask

  task automatic drive(input ins_t in, input logic fl);
    id_valid     = in.v;
    id_rs1       = in.rs1;
    id_rs2       = in.rs2;
    id_rd        = in.rd;
    id_reg_write = in.rw;
    id_mem_read  = in.mr;
    flush        = fl;
  endtask

  // One cycle: present ID inputs just after the edge, queue what must be seen on the falling edge.
  task automatic step(input bit en, input ins_t in, input logic fl, input logic [1:0] efa,
                      input logic [1:0] efb, input logic est, input logic [15:0] ecnt,
                      input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    drive(in, fl);
    if (en) begin
      e.tag = tag; e.fa = efa; e.fb = efb; e.st = est; e.cnt = ecnt;
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 4; i++) step(1'b0, NOP, 1'b0, 2'b00, 2'b00, 1'b0, 16'd0, "");
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      chk({e.tag, "_fa"},  32'(forward_a),   32'(e.fa));
      chk({e.tag, "_fb"},  32'(forward_b),   32'(e.fb));
      chk({e.tag, "_st"},  32'(stall),       32'(e.st));
      chk({e.tag, "_cnt"}, 32'(stall_count), 32'(e.cnt));
    end
  end

  initial begin
    exp_t e0;
    drive(USE7, 1'b0);
    e0.tag = "in_rst"; e0.fa = 2'b00; e0.fb = 2'b00; e0.st = 1'b0; e0.cnt = 16'd0;
    sb.push_back(e0);
    @(negedge clk); @(negedge clk);
    #1 rst_n = 1'b1;
    step(1'b1, USE7, 1'b0, 2'b00, 2'b00, 1'b0, 16'd0, "post_rst");
    drain();

`ifdef FORWARDING_EN
    step(1'b1, ADD5,  1'b0, 2'b00, 2'b00, 1'b0, 16'd0, "a_prod");
    step(1'b1, USE5A, 1'b0, 2'b00, 2'b00, 1'b0, 16'd0, "a_cons");
    step(1'b1, NOP,   1'b0, 2'b10, 2'b00, 1'b0, 16'd0, "a_fwd_mem");
    step(1'b1, NOP,   1'b0, 2'b00, 2'b00, 1'b0, 16'd0, "a_after");
    drain();
    step(1'b1, ADD5,  1'b0, 2'b00, 2'b00, 1'b0, 16'd0, "b_prod");
    step(1'b1, IND8,  1'b0, 2'b00, 2'b00, 1'b0, 16'd0, "b_ind");
    step(1'b1, USE5B, 1'b0, 2'b00, 2'b00, 1'b0, 16'd0, "b_cons");
    step(1'b1, NOP,   1'b0, 2'b00, 2'b01, 1'b0, 16'd0, "b_fwd_wb");
    drain();
    step(1'b1, ADD5,  1'b0, 2'b00, 2'b00, 1'b0, 16'd0, "p_prod1");
    step(1'b1, ADD5,  1'b0, 2'b00, 2'b00, 1'b0, 16'd0, "p_prod2");
    step(1'b1, USE5B, 1'b0, 2'b00, 2'b00, 1'b0, 16'd0, "p_cons");
    step(1'b1, NOP,   1'b0, 2'b00, 2'b10, 1'b0, 16'd0, "p_mem_wins");
    drain();
    step(1'b1, LW7,   1'b0, 2'b00, 2'b00, 1'b0, 16'd0, "c_load");
    step(1'b1, USE7,  1'b0, 2'b00, 2'b00, 1'b1, 16'd0, "c_stall");
    step(1'b1, USE7,  1'b0, 2'b00, 2'b00, 1'b0, 16'd1, "c_bubble");
    step(1'b1, NOP,   1'b0, 2'b01, 2'b00, 1'b0, 16'd1, "c_fwd_wb");
    cbase = 16'd1;
`else
    step(1'b1, ADD5,  1'b0, 2'b00, 2'b00, 1'b0, 16'd0, "a_prod");
    step(1'b1, USE5A, 1'b0, 2'b00, 2'b00, 1'b1, 16'd0, "a_st_ex");
    step(1'b1, USE5A, 1'b0, 2'b00, 2'b00, 1'b1, 16'd1, "a_st_mem");
    step(1'b1, USE5A, 1'b0, 2'b00, 2'b00, 1'b0, 16'd2, "a_go");
    step(1'b1, NOP,   1'b0, 2'b00, 2'b00, 1'b0, 16'd2, "a_after");
    drain();
    step(1'b1, ADD5,  1'b0, 2'b00, 2'b00, 1'b0, 16'd2, "b_prod");
    step(1'b1, IND8,  1'b0, 2'b00, 2'b00, 1'b0, 16'd2, "b_ind");
    step(1'b1, USE5B, 1'b0, 2'b00, 2'b00, 1'b1, 16'd2, "b_st_mem");
    step(1'b1, USE5B, 1'b0, 2'b00, 2'b00, 1'b0, 16'd3, "b_go");
    step(1'b1, NOP,   1'b0, 2'b00, 2'b00, 1'b0, 16'd3, "b_after");
    drain();
    step(1'b1, ADD5,  1'b0, 2'b00, 2'b00, 1'b0, 16'd3, "p_prod1");
    step(1'b1, ADD5,  1'b0, 2'b00, 2'b00, 1'b0, 16'd3, "p_prod2");
    step(1'b1, USE5B, 1'b0, 2'b00, 2'b00, 1'b1, 16'd3, "p_st_ex");
    step(1'b1, USE5B, 1'b0, 2'b00, 2'b00, 1'b1, 16'd4, "p_st_mem");
    step(1'b1, USE5B, 1'b0, 2'b00, 2'b00, 1'b0, 16'd5, "p_go");
    drain();
    step(1'b1, LW7,   1'b0, 2'b00, 2'b00, 1'b0, 16'd5, "c_load");
    step(1'b1, USE7,  1'b0, 2'b00, 2'b00, 1'b1, 16'd5, "c_st_ex");
    step(1'b1, USE7,  1'b0, 2'b00, 2'b00, 1'b1, 16'd6, "c_st_mem");
    step(1'b1, USE7,  1'b0, 2'b00, 2'b00, 1'b0, 16'd7, "c_go");
    cbase = 16'd7;
`endif
    drain();

    // x0 never forwards or stalls, and a flush suppresses the stall and bubbles EX.
    step(1'b1, ADD0, 1'b0, 2'b00, 2'b00, 1'b0, cbase, "x0_add");
    step(1'b1, LW0,  1'b0, 2'b00, 2'b00, 1'b0, cbase, "x0_lw");
    step(1'b1, USE0, 1'b0, 2'b00, 2'b00, 1'b0, cbase, "x0_use");
    step(1'b1, NOP,  1'b0, 2'b00, 2'b00, 1'b0, cbase, "x0_ex");
    step(1'b1, NOP,  1'b0, 2'b00, 2'b00, 1'b0, cbase, "x0_mem");
    drain();
    step(1'b1, LW7,  1'b0, 2'b00, 2'b00, 1'b0, cbase, "fl_load");
    step(1'b1, LW9,  1'b1, 2'b00, 2'b00, 1'b0, cbase, "fl_flush");
    step(1'b1, USE9, 1'b0, 2'b00, 2'b00, 1'b0, cbase, "fl_bubble");
    step(1'b1, NOP,  1'b0, 2'b00, 2'b00, 1'b0, cbase, "fl_after");
    drain();

    @(negedge clk);
    force dut.stall_count_q = 16'hFFFD;
    step(1'b0, NOP, 1'b0, 2'b00, 2'b00, 1'b0, 16'd0, "");
    @(negedge clk);
    release dut.stall_count_q;
`ifdef FORWARDING_EN
    step(1'b1, LW7,  1'b0, 2'b00, 2'b00, 1'b0, 16'hFFFD, "s_ld1");
    step(1'b1, USE7, 1'b0, 2'b00, 2'b00, 1'b1, 16'hFFFD, "s_st1");
    step(1'b1, USE7, 1'b0, 2'b00, 2'b00, 1'b0, 16'hFFFE, "s_go1");
    step(1'b1, LW7,  1'b0, 2'b01, 2'b00, 1'b0, 16'hFFFE, "s_ld2");
    step(1'b1, USE7, 1'b0, 2'b00, 2'b00, 1'b1, 16'hFFFE, "s_st2");
    step(1'b1, USE7, 1'b0, 2'b00, 2'b00, 1'b0, 16'hFFFF, "s_go2");
    step(1'b1, LW7,  1'b0, 2'b01, 2'b00, 1'b0, 16'hFFFF, "s_ld3");
    step(1'b1, USE7, 1'b0, 2'b00, 2'b00, 1'b1, 16'hFFFF, "s_st3");
    step(1'b1, USE7, 1'b0, 2'b00, 2'b00, 1'b0, 16'hFFFF, "s_sat");
`else
    step(1'b1, LW7,  1'b0, 2'b00, 2'b00, 1'b0, 16'hFFFD, "s_ld1");
    step(1'b1, USE7, 1'b0, 2'b00, 2'b00, 1'b1, 16'hFFFD, "s_st1a");
    step(1'b1, USE7, 1'b0, 2'b00, 2'b00, 1'b1, 16'hFFFE, "s_st1b");
    step(1'b1, USE7, 1'b0, 2'b00, 2'b00, 1'b0, 16'hFFFF, "s_go1");
    step(1'b1, LW7,  1'b0, 2'b00, 2'b00, 1'b0, 16'hFFFF, "s_ld2");
    step(1'b1, USE7, 1'b0, 2'b00, 2'b00, 1'b1, 16'hFFFF, "s_st2a");
    step(1'b1, USE7, 1'b0, 2'b00, 2'b00, 1'b1, 16'hFFFF, "s_st2b");
    step(1'b1, USE7, 1'b0, 2'b00, 2'b00, 1'b0, 16'hFFFF, "s_sat");
`endif
    drain();

    // Reset in the middle of a stall cycle must take effect without waiting for a clock.
    step(1'b1, LW7, 1'b0, 2'b00, 2'b00, 1'b0, 16'hFFFF, "r_load");
    @(posedge clk);
    #1 drive(USE7, 1'b0);
    #1 chk("r_pre_stall", 32'(stall), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("r_async_st",  32'(stall),       32'd0);
    chk("r_async_cnt", 32'(stall_count), 32'd0);
    chk("r_async_fa",  32'(forward_a),   32'd0);
    chk("r_async_fb",  32'(forward_b),   32'd0);
    @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    step(1'b1, USE7, 1'b0, 2'b00, 2'b00, 1'b0, 16'd0, "r_post");
    step(1'b1, NOP,  1'b0, 2'b00, 2'b00, 1'b0, 16'd0, "r_residue");
    step(1'b1, NOP,  1'b0, 2'b00, 2'b00, 1'b0, 16'd0, "r_idle");

    @(negedge clk);
    #1;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
